// File: rtl/mux_4x1_rr_sequencer.sv
// Round-robin sequencer for a 4:1 mux.
// It picks a requesting channel and drives the mux selects. After one
// settle cycle it captures the mux output. It then holds that word on a
// valid/ready port until it is accepted, and acknowledges the served channel.
//
// Output handshake: the word transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises, out_data and the selects stay
// frozen until that transfer happens. ack[g] is the transfer strobe for the
// granted channel.
module mux_4x1_rr_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] y_in,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ack,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       g_q, g_d;
    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [1:0]       arb_idx;
    logic             arb_found;

    // Round-robin search: first requester at or after last+1, wrapping 3 -> 0.
    always_comb begin
        logic [1:0] cand;
        arb_idx   = last_q + 2'd1;
        arb_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!arb_found && req[cand]) begin
                arb_idx   = cand;
                arb_found = 1'b1;
            end
        end
    end

    // Next-state logic. Every register holds its value unless a state acts on it.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                // The grant only moves when some channel is asking.
                if (arb_found) begin
                    g_d     = arb_idx;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // The select has been stable for a full cycle, so y_in is
                // valid now. The word is committed even if req drops here.
                data_d  = y_in;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = g_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers. Reset wins over everything and drops any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 2'd0;
            last_q  <= 2'd3;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Acknowledge the granted channel only during an actual transfer in HOLD.
    always_comb begin
        ack = 4'b0000;
        if (state_q == HOLD && valid_q && out_ready) begin
            ack[g_q] = 1'b1;
        end
    end

    assign s1        = g_q[1];
    assign s0        = g_q[0];
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_4x1_rr_sequencer.sv
// Bench for mux_4x1_rr_sequencer. A 4:1 mux model with inputs i<n> = n is
// wired between the selects and y_in, so every captured word names the
// channel it came from.
module tb_mux_4x1_rr_sequencer;
    localparam int WIDTH = 3;
    localparam int EW    = 4 + WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] y_in;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ack;
    logic [1:0]       state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_count     = 0;
    int cyc          = 0;
    int hs_cyc_q[$];
    logic [EW-1:0] exp_q[$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: y = i<{s1,s0}> with i0..i3 = 0..3.
    always_comb begin
        case ({s1, s0})
            2'b00:   y_in = 3'd0;
            2'b01:   y_in = 3'd1;
            2'b10:   y_in = 3'd2;
            default: y_in = 3'd3;
        endcase
    end

    mux_4x1_rr_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .y_in      (y_in),
        .s1        (s1),
        .s0        (s0),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transfer for channel ch: data = ch, ack one-hot at ch.
    task automatic push_exp(input logic [1:0] ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        exp_q.push_back({oh, 3'(ch)});
    endtask

    // Wait for n more transfers, bounded by a cycle budget.
    task automatic wait_hs(input int n, input int budget);
        int target;
        int left;
        target = hs_count + n;
        left   = budget;
        while (hs_count < target && left > 0) begin
            tick();
            left--;
        end
        if (hs_count < target) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_hs timeout: got %0d transfers expected %0d", hs_count, target);
        end
    endtask

    // Scoreboard monitor: at each negedge, a transfer pops and compares one
    // expected word. Without a transfer, ack must be zero.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_transfer: got data %0d ack %b expected none", out_data, ack);
                end else begin
                    e = exp_q.pop_front();
                    check("hs_data", 8'(out_data), 8'(e[WIDTH-1:0]));
                    check("hs_ack", 8'(ack), 8'(e[EW-1:WIDTH]));
                end
            end else begin
                check("idle_ack", 8'(ack), 8'd0);
            end
        end
    end

    // Watchdog against any hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_before;

        // Reset with all channels requesting.
        rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_sel",   8'({s1, s0}), 8'd0);
        check("rst_valid", 8'(out_valid), 8'd0);
        check("rst_data",  8'(out_data),  8'd0);
        check("rst_ack",   8'(ack),       8'd0);
        check("rst_state", 8'(state_dbg), 8'd0);

        // Round-robin with req = 1111: 0,1,2,3,0,1, one transfer every 3 cycles.
        tick();
        rst = 1'b0; out_ready = 1'b1; req = 4'b1111;
        hs_cyc_q.delete();
        push_exp(2'd0); push_exp(2'd1); push_exp(2'd2);
        push_exp(2'd3); push_exp(2'd0); push_exp(2'd1);
        wait_hs(6, 40);
        req = 4'b0000;
        check("rr_count", 8'(hs_cyc_q.size()), 8'd6);
        if (hs_cyc_q.size() >= 6) begin
            for (int i = 1; i < 6; i++) begin
                check("rr_gap", 8'(hs_cyc_q[i] - hs_cyc_q[i-1]), 8'd3);
            end
        end

        // Single request on channel 2.
        tick();
        req = 4'b0100; push_exp(2'd2);
        tick();
        @(negedge clk);
        check("sr_settle_sel",   8'({s1, s0}), 8'd2);
        check("sr_settle_valid", 8'(out_valid), 8'd0);
        check("sr_settle_state", 8'(state_dbg), 8'd1);
        tick();
        @(negedge clk);
        check("sr_hold_valid", 8'(out_valid), 8'd1);
        check("sr_hold_data",  8'(out_data),  8'd2);
        check("sr_hold_ack",   8'(ack),       8'h04);
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("sr_after_valid", 8'(out_valid), 8'd0);
        check("sr_after_ack",   8'(ack),       8'd0);
        check("sr_after_state", 8'(state_dbg), 8'd0);

        // Backpressure on channel 1: 5 cycles stalled, transfer in the 6th.
        tick();
        req = 4'b0010; out_ready = 1'b0; push_exp(2'd1);
        tick();
        tick();
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) out_ready = 1'b1;
            @(negedge clk);
            check("bp_valid", 8'(out_valid), 8'd1);
            check("bp_data",  8'(out_data),  8'd1);
            check("bp_sel",   8'({s1, s0}), 8'd1);
            check("bp_ack",   8'(ack), (k == 6) ? 8'h02 : 8'h00);
            tick();
        end
        req = 4'b0000;

        // Fairness: serve 3, then req = 1001 gives 0 and then 3.
        req = 4'b1000; push_exp(2'd3);
        wait_hs(1, 12);
        req = 4'b1001; push_exp(2'd0); push_exp(2'd3);
        wait_hs(2, 20);
        req = 4'b0000;

        // Reset during SETTLE for channel 1 discards the word.
        tick();
        req = 4'b0010;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mr_settle_sel", 8'({s1, s0}), 8'd1);
        hs_before = hs_count;
        tick();
        rst = 1'b0; req = 4'b0000;
        @(negedge clk);
        check("mr_valid", 8'(out_valid), 8'd0);
        check("mr_data",  8'(out_data),  8'd0);
        check("mr_sel",   8'({s1, s0}), 8'd0);
        check("mr_ack",   8'(ack),       8'd0);
        check("mr_state", 8'(state_dbg), 8'd0);
        for (int k = 0; k < 5; k++) tick();
        check("mr_no_transfer", 8'(hs_count - hs_before), 8'd0);

        check("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
